// File: rtl/neuron_mac_lanes.sv
// Multi-lane fixed-point neuron: weight/bias store, pipelined MAC over input beats,
// saturating accumulate, bias add and activation with a ready/valid result port.
module neuron_mac_lanes #(
    parameter int unsigned layerNo   = 0,
    parameter int unsigned neuronNo  = 0,
    parameter int unsigned numWeight = 784,
    parameter int unsigned dataWidth = 16,
    parameter int unsigned fracBits  = 12,
    parameter int unsigned lanes     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [lanes*dataWidth-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         weightValid,
    input  logic [31:0]                  weightValue,
    input  logic                         biasValid,
    input  logic [31:0]                  biasValue,
    input  logic [31:0]                  config_layer_num,
    input  logic [31:0]                  config_neuron_num,
    input  logic [1:0]                   act_mode,
    output logic [dataWidth-1:0]         out,
    output logic                         outvalid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         wr_err
);
    localparam int unsigned DW   = dataWidth;
    localparam int unsigned NB   = (numWeight + lanes - 1) / lanes;
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned SW   = PW + $clog2(lanes);
    localparam int unsigned ACCW = PW + 8;
    localparam int unsigned WAW  = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam int unsigned BCW  = $clog2(NB + 1);
    localparam int unsigned IXW  = $clog2(NB * lanes) + 1;

    localparam logic signed [ACCW-1:0] QMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] QMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCUM, BIAS, ACT, OUT} state_t;

    state_t                  state;
    logic [BCW-1:0]          beat_cnt;
    logic signed [ACCW-1:0]  acc;
    logic signed [DW-1:0]    wmem [numWeight];
    logic signed [DW-1:0]    bias_reg;
    logic [WAW-1:0]          wptr;
    logic signed [DW-1:0]    lane_w [lanes];
    logic signed [PW-1:0]    prod [lanes];
    logic                    p_valid, p_last;
    logic signed [SW-1:0]    lane_sum;
    logic signed [SW-1:0]    t_sum;
    logic                    t_valid, t_last;
    logic                    accept, wr_sel, wr_ok;
    logic                    unused_bits;

    assign unused_bits = ^{weightValue[31:DW], biasValue[31:DW]};
    assign accept   = in_valid && in_ready;
    assign in_ready = (state == IDLE) || ((state == ACCUM) && (beat_cnt < BCW'(NB)));
    assign busy     = (state != IDLE);
    assign wr_sel   = (config_layer_num == 32'(layerNo)) && (config_neuron_num == 32'(neuronNo));
    assign wr_ok    = wr_sel && (state == IDLE);

    function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                       input logic signed [ACCW-1:0] b);
        logic signed [ACCW:0] s;
        s = (ACCW+1)'(a) + (ACCW+1)'(b);
        if (s[ACCW] != s[ACCW-1])
            sat_add = s[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        else
            sat_add = s[ACCW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] activate(input logic signed [ACCW-1:0] a,
                                                      input logic [1:0] mode);
        logic signed [ACCW-1:0] sh;
        logic signed [DW-1:0]   q;
        sh = a >>> fracBits;
        if (sh > QMAX)      q = QMAX[DW-1:0];
        else if (sh < QMIN) q = QMIN[DW-1:0];
        else                q = sh[DW-1:0];
        if (q < 0) begin
            if (mode == 2'd1)      q = '0;
            else if (mode == 2'd2) q = q >>> 3;
        end
        activate = q;
    endfunction

    // Weight and bias storage survive reset; only the write pointer is cleared.
    always_ff @(posedge clk) begin
        if (wr_ok && weightValid) wmem[wptr] <= weightValue[DW-1:0];
        if (wr_ok && biasValid)   bias_reg   <= biasValue[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            wr_err <= 1'b0;
        end else begin
            if (wr_ok && weightValid)
                wptr <= (wptr == WAW'(numWeight - 1)) ? '0 : wptr + WAW'(1);
            if (wr_sel && (weightValid || biasValid) && (state != IDLE))
                wr_err <= 1'b1;
        end
    end

    // Lanes past the end of the weight vector read as zero.
    always_comb begin
        for (int k = 0; k < lanes; k++) begin
            logic [IXW-1:0] widx;
            widx      = IXW'(beat_cnt) * IXW'(lanes) + IXW'(k);
            lane_w[k] = (widx < IXW'(numWeight)) ? wmem[WAW'(widx)] : '0;
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < lanes; k++)
            lane_sum = lane_sum + SW'(prod[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            t_valid <= 1'b0;
            t_last  <= 1'b0;
            t_sum   <= '0;
            for (int k = 0; k < lanes; k++) prod[k] <= '0;
        end else begin
            p_valid <= accept;
            p_last  <= accept && (beat_cnt == BCW'(NB - 1));
            if (accept)
                for (int k = 0; k < lanes; k++)
                    prod[k] <= $signed(in_data[k*DW +: DW]) * lane_w[k];
            t_valid <= p_valid;
            t_last  <= p_valid && p_last;
            t_sum   <= lane_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            acc      <= '0;
            out      <= '0;
            outvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state    <= ACCUM;
                    beat_cnt <= BCW'(1);
                    acc      <= '0;
                end
                ACCUM: begin
                    if (accept) beat_cnt <= beat_cnt + BCW'(1);
                    if (t_valid) acc <= sat_add(acc, ACCW'(t_sum));
                    if (t_valid && t_last) state <= BIAS;
                end
                BIAS: begin
                    acc   <= sat_add(acc, ACCW'(bias_reg) <<< fracBits);
                    state <= ACT;
                end
                ACT: begin
                    out      <= activate(acc, act_mode);
                    outvalid <= 1'b1;
                    state    <= OUT;
                end
                OUT: if (out_ready) begin
                    outvalid <= 1'b0;
                    beat_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Randomized bench for neuron_mac_lanes against a plain-arithmetic dot-product model.
module tb_neuron_mac_lanes;
    localparam int unsigned DW = 16, LN = 4, NW = 6, FB = 12, LAYER = 2, NEURON = 3;
    localparam int unsigned NB = (NW + LN - 1) / LN;

    logic               clk = 1'b0;
    logic               rst;
    logic [LN*DW-1:0]   in_data;
    logic               in_valid, in_ready;
    logic               weightValid, biasValid;
    logic [31:0]        weightValue, biasValue;
    logic [31:0]        config_layer_num, config_neuron_num;
    logic [1:0]         act_mode;
    logic [DW-1:0]      out;
    logic               outvalid, out_ready, busy, wr_err;

    int n_cmp = 0, n_bad = 0;
    int m_w [NW];
    int m_bias, m_ptr;
    logic m_err;

    always #5 clk = ~clk;

    neuron_mac_lanes #(.layerNo(LAYER), .neuronNo(NEURON), .numWeight(NW), .dataWidth(DW),
                       .fracBits(FB), .lanes(LN)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .weightValid(weightValid), .weightValue(weightValue), .biasValid(biasValid),
        .biasValue(biasValue), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .act_mode(act_mode), .out(out),
        .outvalid(outvalid), .out_ready(out_ready), .busy(busy), .wr_err(wr_err));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 1) == 1) return 16'($urandom());
        return 16'(int'($urandom_range(0, 16383)) - 8192);
    endfunction

    // Dot product over the first NW inputs, plus bias in the same Q format.
    function automatic logic [15:0] ref_out(input logic [15:0] x [LN*NB], input logic [1:0] mode);
        longint s, lim;
        int q;
        s = 0;
        for (int i = 0; i < NW; i++) s += longint'($signed(x[i])) * longint'(m_w[i]);
        s += longint'(m_bias) * (longint'(1) << FB);
        lim = longint'(1) << 39;
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
        s = s >>> FB;
        if (s > 32767) q = 32767;
        else if (s < -32768) q = -32768;
        else q = int'(s);
        if (mode == 2'd1 && q < 0) q = 0;
        else if (mode == 2'd2 && q < 0) q = q >>> 3;
        return 16'(q);
    endfunction

    task automatic write(input bit dw, input bit db, input logic [15:0] wv, input logic [15:0] bv,
                         input bit sel);
        config_neuron_num = sel ? NEURON : NEURON + 1;
        weightValid = dw;
        biasValid   = db;
        weightValue = {16'($urandom()), wv};
        biasValue   = {16'($urandom()), bv};
        tick();
        weightValid = 1'b0;
        biasValid   = 1'b0;
        config_neuron_num = NEURON;
        if (sel && dw) begin
            m_w[m_ptr] = int'($signed(wv));
            m_ptr = (m_ptr + 1) % NW;
        end
        if (sel && db) m_bias = int'($signed(bv));
    endtask

    task automatic load_all(input logic [15:0] wv, input logic [15:0] bv);
        for (int i = 0; i < NW; i++) write(1'b1, 1'b0, wv, 16'h0, 1'b1);
        write(1'b0, 1'b1, 16'h0, bv, 1'b1);
    endtask

    task automatic run(input logic [15:0] x [LN*NB], input logic [1:0] mode, input bit gaps,
                       input int hold, input bit bad_write, output logic [15:0] got);
        logic [15:0] exp;
        int lat;
        bit seen;
        exp = ref_out(x, mode);
        act_mode = mode;
        for (int b = 0; b < NB; b++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = {$urandom(), $urandom()};
                repeat ($urandom_range(0, 3)) tick();
            end
            for (int k = 0; k < LN; k++) in_data[k*DW +: DW] = x[b*LN + k];
            in_valid = 1'b1;
            check("in_ready_beat", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom()};
        check("busy_accum", 32'(busy), 1);
        check("in_ready_full", 32'(in_ready), 0);
        lat = 1;
        if (bad_write) begin
            weightValid = 1'b1;
            biasValid   = 1'b1;
            weightValue = $urandom();
            biasValue   = $urandom();
            tick();
            weightValid = 1'b0;
            biasValid   = 1'b0;
            m_err = 1'b1;
            lat = 2;
        end
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (outvalid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check("latency", 32'(lat), 5);
        got = out;
        check("out", 32'(out), 32'(exp));
        check("wr_err", 32'(wr_err), 32'(m_err));
        for (int i = 0; i < hold; i++) begin
            act_mode = 2'($urandom_range(0, 3));
            tick();
            check("hold_out", 32'(out), 32'(exp));
            check("hold_valid", 32'(outvalid), 1);
            check("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", 32'(outvalid), 0);
        check("release_busy", 32'(busy), 0);
        check("release_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        logic [15:0] xv [LN*NB];
        logic [15:0] got;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; weightValid = 1'b0; weightValue = '0;
        biasValid = 1'b0; biasValue = '0; config_layer_num = LAYER; config_neuron_num = NEURON;
        act_mode = 2'd0; out_ready = 1'b0;
        m_ptr = 0; m_err = 1'b0; m_bias = 0;
        foreach (m_w[i]) m_w[i] = 0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out", 32'(out), 0);
        check("rst_outvalid", 32'(outvalid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_err", 32'(wr_err), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Unity weights and inputs over six taps.
        load_all(16'h1000, 16'h0000);
        write(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0);
        foreach (xv[i]) xv[i] = 16'h1000;
        run(xv, 2'd0, 1'b0, 0, 1'b0, got);
        check("unity_sum", 32'(got), 32'h6000);

        foreach (xv[i]) xv[i] = 16'h0000;
        xv[0] = 16'hE000;
        run(xv, 2'd1, 1'b0, 10, 1'b0, got);
        check("relu_neg", 32'(got), 32'h0000);
        run(xv, 2'd2, 1'b1, 2, 1'b0, got);
        check("leaky_neg", 32'(got), 32'hFC00);

        load_all(16'h7FFF, 16'h0000);
        foreach (xv[i]) xv[i] = 16'h7FFF;
        run(xv, 2'd0, 1'b0, 1, 1'b0, got);
        check("pos_sat", 32'(got), 32'h7FFF);

        // Illegal write while busy; weights must stay as loaded.
        load_all(16'h1000, 16'h0000);
        foreach (xv[i]) xv[i] = rnd16();
        run(xv, 2'd0, 1'b1, 1, 1'b1, got);
        foreach (xv[i]) xv[i] = 16'h1000;
        run(xv, 2'd0, 1'b0, 0, 1'b0, got);
        check("after_bad_write", 32'(got), 32'h6000);

        // Seventh write wraps onto the first address, with a simultaneous bias write.
        write(1'b1, 1'b1, 16'h2000, 16'h0800, 1'b1);
        foreach (xv[i]) xv[i] = rnd16();
        run(xv, 2'd3, 1'b1, 0, 1'b0, got);

        // Abort mid-accumulation.
        act_mode = 2'd0;
        for (int k = 0; k < LN; k++) in_data[k*DW +: DW] = 16'h1000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
        check("abort_idle", 32'(busy), 0);
        check("abort_wr_err", 32'(wr_err), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_outvalid", 32'(outvalid), 0);
        end
        foreach (xv[i]) xv[i] = rnd16();
        run(xv, 2'd0, 1'b0, 0, 1'b0, got);

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                int nw;
                nw = int'($urandom_range(1, NW + 2));
                for (int i = 0; i < nw; i++)
                    write(1'b1, $urandom_range(0, 3) == 0, rnd16(), rnd16(),
                          $urandom_range(0, 4) != 0);
            end
            foreach (xv[i]) xv[i] = rnd16();
            run(xv, 2'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 3)),
                $urandom_range(0, 5) == 0, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/neuron_mac_lanes.md
NEURON_MAC_LANES -- requirements
Module: neuron_mac_lanes

Interface
REQ-001 SHALL have parameter layerNo, default 0, layer ID matched against cfg_layer_num.
REQ-002 SHALL have parameter neuronNo, default 0, neuron ID matched against cfg_neuron_num.
REQ-003 SHALL have parameter numWeight, default 784, weights per neuron, >=1.
REQ-004 SHALL have parameter dataWidth, default 16, signed width of inputs, weights, bias and output.
REQ-005 SHALL have parameter fracBits, default 12, fractional bits of the Q format shared by input, weight, bias and output.
REQ-006 SHALL have parameter lanes, default 4, parallel MAC lanes, >=1.
REQ-007 SHALL have port clk, input, 1, the only clock.
REQ-008 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port in_data, input, lanes*dataWidth, input beat; lane k occupies bits [k*dataWidth +: dataWidth].
REQ-010 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input beat handshake.
REQ-011 SHALL have ports weightValid (input, 1) and weightValue (input, 32); weight write strobe and data, low dataWidth bits used.
REQ-012 SHALL have ports biasValid (input, 1) and biasValue (input, 32); bias write strobe and data, low dataWidth bits used.
REQ-013 SHALL have ports config_layer_num and config_neuron_num, input, 32 each, write target select.
REQ-014 SHALL have port act_mode, input, 2; 0 linear, 1 ReLU, 2 leaky ReLU (x>>>3 when negative), 3 reserved (treated as linear).
REQ-015 SHALL have ports out (output, dataWidth), outvalid (output, 1) and out_ready (input, 1), result handshake.
REQ-016 SHALL have ports busy (output, 1) and wr_err (output, 1, sticky).

Function
REQ-017 A write SHALL be selected when config_layer_num==layerNo and config_neuron_num==neuronNo.
REQ-018 Selected weight writes SHALL fill internal memory at addresses 0,1,...,numWeight-1, then wrap to 0.
REQ-019 A selected biasValid SHALL load the bias register; when biasValid and weightValid are both high, both writes SHALL occur.
REQ-020 Weight and bias writes SHALL be accepted only in state IDLE; otherwise the write SHALL be dropped and wr_err SHALL be set until rst.
REQ-021 A computation SHALL take B = ceil(numWeight/lanes) beats; beat j lane k SHALL pair with weight j*lanes+k; lanes with index >= numWeight SHALL contribute 0.
REQ-022 The FSM SHALL have states IDLE, ACCUM, BIAS, ACT, OUT.
REQ-023 IDLE->ACCUM SHALL occur on the first accepted beat; ACCUM->BIAS SHALL occur once beat B-1 has cleared the MAC pipeline.
REQ-024 BIAS->ACT and ACT->OUT SHALL each take exactly 1 cycle; OUT->IDLE SHALL occur on the cycle outvalid&&out_ready.
REQ-025 in_ready SHALL be 1 in IDLE, and in ACCUM while fewer than B beats have been accepted; otherwise 0.
REQ-026 A beat SHALL be accepted on in_valid&&in_ready; gaps in in_valid SHALL be tolerated with no result change.
REQ-027 Each lane SHALL form a registered signed 2*dataWidth product; lane products SHALL be summed in a registered adder stage at 2*dataWidth+clog2(lanes) bits.
REQ-028 The accumulator SHALL be 2*dataWidth+8 bits signed and SHALL saturate to its max/min on overflow, never wrap.
REQ-029 In BIAS, the accumulator SHALL add the sign-extended bias shifted left by fracBits, saturating.
REQ-030 In ACT, out SHALL be the accumulator arithmetically shifted right by fracBits and saturated to dataWidth signed, then activated per act_mode, which is sampled in ACT.
REQ-031 out and outvalid SHALL hold stable in OUT until out_ready; busy SHALL be 1 in every state except IDLE.
REQ-032 Latency from last accepted beat to outvalid SHALL be exactly 5 cycles (product, tree, accumulate, BIAS, ACT).

Reset
REQ-033 rst SHALL set state IDLE, accumulator 0, beat count 0, weight write pointer 0, outvalid 0, out 0, busy 0, wr_err 0, and drain the pipeline.
REQ-034 Weight memory and bias register contents SHALL be undefined-but-unchanged across rst; rst during a computation SHALL abort it with no outvalid.

Verification
REQ-035 lanes=4, numWeight=6, fracBits=12, all weights 0x1000, bias 0, inputs 0x1000 -> B=2, out=0x6000, outvalid 5 cycles after beat 2.
REQ-036 Weights 0x7FFF, inputs 0x7FFF, numWeight=784, act_mode 0 -> out saturates to 0x7FFF.
REQ-037 Sum -0x2000 with act_mode 1 -> out=0x0000; with act_mode 2 -> out=0xFC00.
REQ-038 weightValid asserted while busy -> wr_err=1, memory unchanged, result identical to a run without the write.
REQ-039 out_ready held low 10 cycles in OUT -> out stable, in_ready=0; out_ready high -> IDLE next cycle, in_ready=1.
REQ-040 rst asserted mid-ACCUM then fresh run -> no outvalid from the aborted run; fresh result correct.
